// File: rtl/cic_pdm_pkg.sv
// cic_pdm_pkg: width derivation, parameter range checks and output scaling
// shared by the PDM CIC decimator.
package cic_pdm_pkg;
   localparam int MAX_ACC_W = 42;
   localparam int MAX_OUT_W = 24;

   function automatic int acc_w_of(input int stages, input int decim_log2);
      return stages * decim_log2 + 2;
   endfunction

   function automatic int sh_w_of(input int acc_w);
      return $clog2(acc_w);
   endfunction

   function automatic bit params_ok(input int stages, input int decim_log2, input int out_w);
      return stages >= 1 && stages <= 5 && decim_log2 >= 2 && decim_log2 <= 8 &&
             out_w >= 8 && out_w <= 24;
   endfunction

   // Arithmetic shift, then clamp to the signed range of an out_w-bit word.
   function automatic logic signed [MAX_OUT_W-1:0] sat_shift(input logic signed [MAX_ACC_W-1:0] v,
                                                              input int sh, input int out_w);
      logic signed [MAX_ACC_W-1:0] s, hi, lo;
      s  = v >>> sh;
      hi = MAX_ACC_W'((64'sd1 <<< (out_w - 1)) - 64'sd1);
      lo = ~hi;
      return (s > hi) ? hi[MAX_OUT_W-1:0] : (s < lo) ? lo[MAX_OUT_W-1:0] : s[MAX_OUT_W-1:0];
   endfunction
endpackage

// File: rtl/cic_out_reg.sv
// cic_out_reg: PCM output word register with valid/ready handshake and
// sticky overrun flag; all outputs are registered.
module cic_out_reg
   import cic_pdm_pkg::*;
#(
   parameter int OUT_W = 16
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    load,
   input  logic signed [OUT_W-1:0] din,
   input  logic                    pcm_ready,
   input  logic                    clear_overrun,
   output logic signed [OUT_W-1:0] pcm_out,
   output logic                    pcm_valid,
   output logic                    overrun
);
   always_ff @(posedge clk)
      if (!rst_n) begin
         pcm_out   <= '0;
         pcm_valid <= 1'b0;
         overrun   <= 1'b0;
      end else begin
         pcm_out   <= load ? din : pcm_out;
         pcm_valid <= load || (pcm_valid && !pcm_ready);
         // a set in the same cycle as clear_overrun takes priority
         overrun   <= (load && pcm_valid && !pcm_ready) || (overrun && !clear_overrun);
      end
endmodule

// File: rtl/cic_pdm_decim.sv
// cic_pdm_decim: N-stage CIC decimator turning a 1-bit PDM stream into
// saturated signed PCM words with a valid/ready output.
module cic_pdm_decim
   import cic_pdm_pkg::*;
#(
   parameter  int STAGES     = 3,
   parameter  int DECIM_LOG2 = 6,
   parameter  int OUT_W      = 16,
   localparam int ACC_W      = acc_w_of(STAGES, DECIM_LOG2),
   localparam int SH_W       = sh_w_of(ACC_W)
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic                    en,
   input  logic                    pdm_in,
   input  logic [SH_W-1:0]         shift,
   output logic signed [OUT_W-1:0] pcm_out,
   output logic                    pcm_valid,
   input  logic                    pcm_ready,
   output logic                    overrun,
   input  logic                    clear_overrun
);
   localparam logic [DECIM_LOG2-1:0] CNT_MAX = '1;

   logic [ACC_W-1:0]      integ    [STAGES];
   logic [ACC_W-1:0]      integ_in [STAGES];
   logic [ACC_W-1:0]      dly      [STAGES];
   logic [ACC_W-1:0]      cmb      [STAGES];
   logic [ACC_W-1:0]      cmb_in   [STAGES];
   logic [DECIM_LOG2-1:0] cnt;
   logic                  strobe;
   logic signed [OUT_W-1:0] y;

   if (!params_ok(STAGES, DECIM_LOG2, OUT_W)) begin : g_bad_params
      $error("cic_pdm_decim: parameter out of range");
   end

   assign strobe      = en && cnt == CNT_MAX;
   assign integ_in[0] = pdm_in ? ACC_W'(1) : '1;
   assign cmb_in[0]   = integ[STAGES-1];

   always_ff @(posedge clk)
      cnt <= !rst_n ? '0 : en ? cnt + 1'b1 : cnt;

   // Registered cascade: every stage adds its predecessor's previous value.
   for (genvar i = 0; i < STAGES; i++) begin : g_stage
      if (i > 0) begin : g_link
         assign integ_in[i] = integ[i-1];
         assign cmb_in[i]   = cmb[i-1];
      end
      assign cmb[i] = cmb_in[i] - dly[i];
      always_ff @(posedge clk)
         if (!rst_n) begin
            integ[i] <= '0;
            dly[i]   <= '0;
         end else begin
            integ[i] <= en ? integ[i] + integ_in[i] : integ[i];
            dly[i]   <= strobe ? cmb_in[i] : dly[i];
         end
   end

   assign y = OUT_W'(sat_shift(MAX_ACC_W'($signed(cmb[STAGES-1])), int'(shift), OUT_W));

   cic_out_reg #(.OUT_W(OUT_W)) u_out (
      .clk           (clk),
      .rst_n         (rst_n),
      .load          (strobe),
      .din           (y),
      .pcm_ready     (pcm_ready),
      .clear_overrun (clear_overrun),
      .pcm_out       (pcm_out),
      .pcm_valid     (pcm_valid),
      .overrun       (overrun)
   );
endmodule

// File: tb/tb_cic_pdm_decim.sv
// tb_cic_pdm_decim: directed checks of the default 3-stage, R=64, 16-bit
// decimator against hand-computed CIC outputs.
module tb_cic_pdm_decim;
   localparam int R = 64;

   logic clk = 1'b0;
   logic rst_n = 1'b0, en = 1'b0, pdm_in = 1'b0, pcm_ready = 1'b1, clear_overrun = 1'b0;
   logic [4:0] shift = '0;
   logic signed [15:0] pcm_out;
   logic pcm_valid, overrun;

   int checks = 0, errors = 0;
   int en_div = 1, phase = 0, pidx = 0, c = 0;
   logic [3:0] pat = 4'b1111;
   logic signed [15:0] w = '0;

   cic_pdm_decim dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .en            (en),
      .pdm_in        (pdm_in),
      .shift         (shift),
      .pcm_out       (pcm_out),
      .pcm_valid     (pcm_valid),
      .pcm_ready     (pcm_ready),
      .overrun       (overrun),
      .clear_overrun (clear_overrun)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   // One clock; the PDM pattern advances only on enabled cycles.
   task automatic tick();
      @(posedge clk);
      #1;
      if (en) pidx = (pidx + 1) % 4;
      phase  = (phase + 1) % en_div;
      en     = (phase == 0);
      pdm_in = pat[pidx];
   endtask

   task automatic start(input logic [3:0] p, input int div, input logic [4:0] sh);
      rst_n = 1'b0;
      pcm_ready = 1'b1;
      clear_overrun = 1'b0;
      tick();
      tick();
      check("rst_valid", pcm_valid, 0);
      check("rst_out", pcm_out, 0);
      check("rst_overrun", overrun, 0);
      pat = p;
      en_div = div;
      shift = sh;
      phase = 0;
      pidx = 0;
      en = 1'b1;
      pdm_in = p[0];
      rst_n = 1'b1;
   endtask

   // Edges counted from the previous sample point until pcm_valid is seen.
   task automatic get_word();
      c = 0;
      do begin
         tick();
         c++;
      end while (!pcm_valid && c < 1000);
      check("word_arrives", pcm_valid, 1);
      w = pcm_out;
   endtask

   initial begin
      start(4'b1111, 1, 5'd4);
      get_word();
      check("first_latency", c, R);
      check("ones_w1", w, 2481);
      get_word();
      check("period", c, R);
      check("ones_w2", w, 13390);
      get_word();
      check("ones_w3", w, 16383);
      for (int k = 4; k <= 6; k++) begin
         get_word();
         check("ones_sh4", w, 16384);
         check("no_overrun", overrun, 0);
      end

      start(4'b0000, 1, 5'd3);
      repeat (5) get_word();
      check("zeros_sh3", w, -32768);
      get_word();
      check("zeros_sh3", w, -32768);

      start(4'b1111, 1, 5'd3);
      repeat (5) get_word();
      check("ones_sh3_sat", w, 32767);
      get_word();
      check("ones_sh3_sat", w, 32767);

      start(4'b0101, 1, 5'd0);
      repeat (5) get_word();
      check("alt_sh0", w, 0);
      get_word();
      check("alt_sh0", w, 0);

      start(4'b0111, 1, 5'd4);
      repeat (5) get_word();
      check("75pct_sh4", w, 8192);
      get_word();
      check("75pct_sh4", w, 8192);

      start(4'b1111, 3, 5'd4);
      get_word();
      check("en3_first_latency", c, 3 * (R - 1) + 1);
      check("en3_w1", w, 2481);
      get_word();
      check("en3_period", c, 3 * R);
      check("en3_w2", w, 13390);
      get_word();
      check("en3_period", c, 3 * R);
      check("en3_w3", w, 16383);
      get_word();
      check("en3_w4", w, 16384);

      start(4'b1111, 1, 5'd4);
      pcm_ready = 1'b0;
      repeat (R) tick();
      check("ovr_valid1", pcm_valid, 1);
      check("ovr_out1", pcm_out, 2481);
      check("ovr_none_yet", overrun, 0);
      repeat (R) tick();
      check("ovr_out2", pcm_out, 13390);
      check("ovr_set", overrun, 1);
      repeat (R - 1) tick();
      clear_overrun = 1'b1;
      tick();
      check("ovr_set_wins", overrun, 1);
      check("ovr_out3", pcm_out, 16383);
      tick();
      check("ovr_cleared", overrun, 0);
      check("ovr_valid_held", pcm_valid, 1);
      clear_overrun = 1'b0;
      pcm_ready = 1'b1;
      tick();
      check("accept_clears_valid", pcm_valid, 0);

      start(4'b1111, 1, 5'd4);
      pcm_ready = 1'b0;
      repeat (R) tick();
      check("mid_valid", pcm_valid, 1);
      repeat (10) tick();
      rst_n = 1'b0;
      tick();
      check("mid_rst_valid", pcm_valid, 0);
      check("mid_rst_out", pcm_out, 0);
      phase = 0;
      pidx = 0;
      en = 1'b1;
      pcm_ready = 1'b1;
      rst_n = 1'b1;
      get_word();
      check("mid_rst_latency", c, R);
      check("mid_rst_w1", w, 2481);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
